// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared definitions for the wait-stated memory controller: default
//   geometry/timing constants, the FSM state encoding and an address range
//   helper used by both the controller and the storage array.
package mem_ctrl_pkg;

  localparam int DW_DEF    = 8;    // data/bus width
  localparam int AW_DEF    = 8;    // address width
  localparam int DEPTH_DEF = 256;  // implemented words
  localparam int WAIT_DEF  = 2;    // wait-state cycles per access
  localparam int CNT_W     = 4;    // wait counter holds 0..15

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Plain-vector copies of the encoding for the state register.
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_DONE   = ST_DONE;

  // True when the (zero-extended) address maps onto an implemented word.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if
//   Processor-side bus/handshake bundle of the memory controller.
//   slave  modport : seen by mem_ctrl
//   master modport : seen by the processor (or a testbench)
//   Signals: bus_in/bus_out/bus_oe (shared bus), mar_in/mbr_in/mbr_out
//   (register strobes), enable/rnw (access start), mfc/busy/err (status),
//   mar_value/mbr_value (register observation).
interface mem_ctrl_if import mem_ctrl_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          mar_in;
  logic          mbr_in;
  logic          mbr_out;
  logic          enable;
  logic          rnw;
  logic          mfc;
  logic          busy;
  logic          err;
  logic [AW-1:0] mar_value;
  logic [DW-1:0] mbr_value;

  modport slave (
    input  bus_in, mar_in, mbr_in, mbr_out, enable, rnw,
    output bus_out, bus_oe, mfc, busy, err, mar_value, mbr_value
  );

  modport master (
    output bus_in, mar_in, mbr_in, mbr_out, enable, rnw,
    input  bus_out, bus_oe, mfc, busy, err, mar_value, mbr_value
  );

endinterface

// File: rtl/mem_ctrl_array.sv
// mem_array
//   Synchronous single-port storage, DW x DEPTH. One write port and one
//   registered read port sharing the address. Contents are never reset.
//   Ports: clk_i, we_i, addr_i, wdata_i, rdata_o (value of mem[addr_i]
//   sampled at the previous rising edge).
module mem_array import mem_ctrl_pkg::*; #(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port (range-guarded) and registered read port.
  always_ff @(posedge clk_i) begin
    if (we_i && addr_ok(32'(addr_i), $unsigned(DEPTH))) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Wait-stated memory controller with MAR/MBR registers on a shared bus.
//   An enable in IDLE snapshots MAR, MBR and rnw; the access then runs
//   WAIT -> ACCESS -> DONE and reports completion with a one-cycle mfc
//   (and err for out-of-range addresses) in the cycle after DONE, which is
//   also the first cycle a new enable can be accepted.
//   Ports: CLK, RST (async, active-high), bus (mem_ctrl_if.slave).
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAIT  = WAIT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  mem_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    mar_q, mar_d;
  logic [DW-1:0]    mbr_q, mbr_d;
  logic [AW-1:0]    addr_q, addr_d;     // in-flight address
  logic [DW-1:0]    wdata_q, wdata_d;   // in-flight write data
  logic             rnw_q, rnw_d;
  logic             oor_q, oor_d;       // in-flight address out of range
  logic             mfc_q, mfc_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             we_s;
  logic [DW-1:0]    rdata_s;

  mem_array #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (we_s),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_s)
  );

  // Write strobe only in ACCESS, only for in-range writes; reset kills it at once.
  assign we_s = (state_q == S_ACCESS) && !rnw_q && !oor_q;

  // Next-state logic for the FSM, the bus registers and the status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rnw_d   = rnw_q;
    oor_d   = oor_q;

    // MAR/MBR always follow their strobes; the in-flight copies are separate.
    if (bus.mar_in) begin
      mar_d = bus.bus_in[AW-1:0];
    end else begin
      mar_d = mar_q;
    end
    if (bus.mbr_in) begin
      mbr_d = bus.bus_in;
    end else begin
      mbr_d = mbr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          addr_d  = mar_q;
          wdata_d = mbr_q;
          rnw_d   = bus.rnw;
          oor_d   = !addr_ok(32'(mar_q), $unsigned(DEPTH));
          cnt_d   = WAIT_C;
          if (WAIT_C == 4'd0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= also catches a zero count so the FSM can never stall here
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        // Read data arrives from the registered port now; it overrides any
        // mbr_in seen during the access.
        if (rnw_q) begin
          if (oor_q) begin
            mbr_d = '0;
          end else begin
            mbr_d = rdata_s;
          end
        end else begin
          mbr_d = mbr_d;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status is registered, so completion shows one cycle after DONE; busy
    // spans acceptance through that completion cycle.
    mfc_d  = (state_q == S_DONE);
    err_d  = (state_q == S_DONE) && oor_q;
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= '0;
      mbr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rnw_q   <= 1'b0;
      oor_q   <= 1'b0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rnw_q   <= rnw_d;
      oor_q   <= oor_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_out   = mbr_q;
  assign bus.bus_oe    = bus.mbr_out;
  assign bus.mfc       = mfc_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.mar_value = mar_q;
  assign bus.mbr_value = mbr_q;

endmodule
